// File: rtl/uart_num_parser.sv
// uart_num_parser: turns an ASCII byte stream of signed decimal integers into
// two's-complement values with one-cycle value/error/end-of-line strobes.
module uart_num_parser #(
   parameter int VALUE_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [7:0]         rx_data,
   input  logic               rx_done,
   output logic [VALUE_W-1:0] num_value,
   output logic               num_valid,
   output logic               num_err,
   output logic               eol
);
   typedef enum logic [1:0] {IDLE, SIGN, DIGITS, SKIP} state_t;
   state_t               state_q, state_d;
   logic [VALUE_W:0]     acc_q, acc_d;
   logic                 neg_q, neg_d;
   logic [VALUE_W-1:0]   value_q, value_d;
   logic                 valid_q, valid_d, err_q, err_d, eol_q, eol_d;
   logic                 is_digit, is_minus, is_sep;
   logic [VALUE_W:0]     digit;
   logic [VALUE_W+4:0]   next_acc, limit;
   assign is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
   assign is_minus = rx_data == 8'h2D;
   assign is_sep   = rx_data == 8'h20 || rx_data == 8'h0D || rx_data == 8'h0A;
   assign digit    = (VALUE_W+1)'(rx_data[3:0]);
   // Four guard bits hold acc*10+9 exactly, so the range check sees the true value.
   assign next_acc = {4'b0, acc_q} * (VALUE_W+5)'(10) + (VALUE_W+5)'(rx_data[3:0]);
   assign limit    = ((VALUE_W+5)'(1) << (VALUE_W-1)) - (VALUE_W+5)'(!neg_q);
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      value_d = value_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      eol_d   = rx_done && rx_data == 8'h0A;
      if (rx_done) begin
         case (state_q)
            IDLE: begin
               if (is_digit) begin
                  acc_d   = digit;
                  neg_d   = 1'b0;
                  state_d = DIGITS;
               end else if (is_minus) begin
                  acc_d   = '0;
                  neg_d   = 1'b1;
                  state_d = SIGN;
               end else if (!is_sep) begin
                  err_d   = 1'b1;
                  state_d = SKIP;
               end
            end
            SIGN: begin
               err_d   = !is_digit;
               acc_d   = is_digit ? digit : acc_q;
               state_d = is_digit ? DIGITS : is_sep ? IDLE : SKIP;
            end
            DIGITS: begin
               if (is_digit && next_acc <= limit) begin
                  acc_d = next_acc[VALUE_W:0];
               end else if (is_sep) begin
                  value_d = neg_q ? -acc_q[VALUE_W-1:0] : acc_q[VALUE_W-1:0];
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = SKIP;
               end
            end
            default: state_d = is_sep ? IDLE : SKIP;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         value_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         eol_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         value_q <= value_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         eol_q   <= eol_d;
      end
   end
   assign num_value = value_q;
   assign num_valid = valid_q;
   assign num_err   = err_q;
   assign eol       = eol_q;
endmodule

// File: tb/tb_uart_num_parser.sv
// tb_uart_num_parser: directed and random byte streams checked against a
// string-based token model that reparses each token from its text.
module tb_uart_num_parser;
   localparam int VALUE_W = 16;
   logic               clk = 1'b0;
   logic               rst_n;
   logic [7:0]         rx_data;
   logic               rx_done;
   logic [VALUE_W-1:0] num_value;
   logic               num_valid, num_err, eol;
   int                 checks = 0;
   int                 errors = 0;
   string              tok = "";
   bit                 bad = 1'b0;
   logic [VALUE_W-1:0] exp_value = '0;
   logic               exp_valid, exp_err, exp_eol;
   uart_num_parser #(.VALUE_W(VALUE_W)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_done(rx_done),
      .num_value(num_value), .num_valid(num_valid), .num_err(num_err), .eol(eol)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask
   // Signed value of an optional '-' followed by decimal digits.
   function automatic longint parse(input string s);
      longint m = 0;
      for (int i = (s[0] == "-") ? 1 : 0; i < s.len(); i++) m = m * 10 + longint'(s[i] - 8'h30);
      return (s[0] == "-") ? -m : m;
   endfunction
   // A prefix stays legal while it looks like -?[0-9]* and its value fits.
   function automatic bit legal(input string s);
      for (int i = 0; i < s.len(); i++)
         if (!(i == 0 && s[i] == "-") && !(s[i] >= "0" && s[i] <= "9")) return 1'b0;
      return parse(s) <= 32767 && parse(s) >= -32768;
   endfunction
   task automatic model(input logic [7:0] b);
      exp_eol = b == 8'h0A;
      if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
         if (!bad && tok.len() > 0) begin
            if (tok == "-") exp_err = 1'b1;
            else begin
               exp_valid = 1'b1;
               exp_value = VALUE_W'(parse(tok));
            end
         end
         tok = "";
         bad = 1'b0;
      end else if (!bad) begin
         tok = $sformatf("%s%c", tok, b);
         if (!legal(tok)) begin
            exp_err = 1'b1;
            bad = 1'b1;
         end
      end
   endtask
   // Called at a falling edge: drive, let the rising edge sample, check the result.
   task automatic step(input logic [7:0] b, input logic done);
      rx_data = b;
      rx_done = done;
      exp_valid = 1'b0;
      exp_err = 1'b0;
      exp_eol = 1'b0;
      if (!rst_n) begin
         tok = "";
         bad = 1'b0;
         exp_value = '0;
      end else if (done) model(b);
      @(posedge clk);
      #1;
      chk("num_valid", num_valid, exp_valid);
      chk("num_err", num_err, exp_err);
      chk("eol", eol, exp_eol);
      chk("num_value", num_value, exp_value);
      @(negedge clk);
   endtask
   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) step(s[i], 1'b1);
   endtask
   initial begin
      rst_n = 1'b0;
      rx_done = 1'b0;
      rx_data = 8'h00;
      @(negedge clk);
      step(8'h39, 1'b0);
      step(8'h00, 1'b0);
      rst_n = 1'b1;
      send_str("12 -34\n");
      send_str("32767 ");
      send_str("-32768 ");
      send_str("32768 ");
      send_str("-32769 ");
      send_str("1a2 5\n");
      send_str("- 7\r\n");
      send_str("--5 -5x 3");
      send_str("99");
      rst_n = 1'b0;
      step(8'h00, 1'b0);
      rst_n = 1'b1;
      send_str(" 4 ");
      send_str("0 00 -0 007 -00032768\n");
      for (int n = 0; n < 1500; n++) begin
         int r = $urandom_range(0, 21);
         logic [7:0] b;
         if (r == 21) begin
            send_str($sformatf("%0d ", $signed($urandom_range(0, 80000)) - 40000));
            continue;
         end
         b = r < 10 ? 8'h30 + 8'(r) : r == 10 ? 8'h2D : r == 11 ? 8'h20 : r == 12 ? 8'h0D :
             r == 13 ? 8'h0A : r == 14 ? 8'h61 : r == 15 ? 8'($urandom) : 8'h30 + 8'($urandom_range(0, 9));
         step(b, $urandom_range(0, 3) != 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
